// File: rtl/fft_twiddle_sequencer.sv
// Radix-2 DIT FFT issue sequencer: walks stages/butterflies, drives the
// twiddle ROM address and emits operand addresses aligned to ROM q.
// Ports: clk, rst_n (async, active-low), start, stall -> busy, done,
//   twiddle_addr[8:0], bfly_valid, addr_a, addr_b, stage[3:0].
// FFT_BITREV_EN adds a bit-reversed LOAD phase with load_valid/load_addr.
module fft_twiddle_sequencer #(
  parameter int LOG2N     = 10,
  parameter int ROM_LAT   = 1,
  parameter int STAGE_GAP = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stall,
  output logic             busy,
  output logic             done,
  output logic [8:0]       twiddle_addr,
  output logic             bfly_valid,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [3:0]       stage
`ifdef FFT_BITREV_EN
  ,
  output logic             load_valid,
  output logic [LOG2N-1:0] load_addr
`endif
);

  typedef logic [LOG2N-1:0] idx_t;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, GAP, FLUSH} state_t;

  localparam idx_t       K_LAST   = idx_t'((1 << (LOG2N - 1)) - 1);
  localparam logic [3:0] S_LAST   = 4'(LOG2N - 1);
  localparam logic [3:0] GAP_LAST = 4'(STAGE_GAP - 1);
  localparam logic [1:0] F_LAST   = 2'(ROM_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] s_q, s_d;
  idx_t       k_q, k_d;
  logic [3:0] g_q, g_d;
  logic [1:0] f_q, f_d;
  logic       done_q, done_d;
  logic       issue_v;

`ifdef FFT_BITREV_EN
  localparam idx_t L_LAST = idx_t'((1 << LOG2N) - 1);
  idx_t lc_q, lc_d;
`endif

  idx_t        half, pmask, p, j, a_i, b_i;
  logic [17:0] tw_w;

  always_comb begin
    half  = idx_t'(1) << s_q;
    pmask = half - idx_t'(1);
    p     = k_q & pmask;
    j     = k_q >> s_q;
    a_i   = (j << (s_q + 4'd1)) | p;
    b_i   = a_i | half;
    // 512-entry table covers every stage: index step halves per stage
    tw_w  = 18'(p) << (4'd9 - s_q);
  end

  assign twiddle_addr = tw_w[8:0];
  assign issue_v      = (state_q == RUN) && !stall;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    g_d     = g_q;
    f_d     = f_q;
    done_d  = 1'b0;
`ifdef FFT_BITREV_EN
    lc_d    = lc_q;
`endif
    unique case (state_q)
      IDLE: begin
        s_d = '0;
        k_d = '0;
        // a start coinciding with the done pulse waits one cycle
        if (start && !done_q) begin
`ifdef FFT_BITREV_EN
          state_d = LOAD;
          lc_d    = '0;
`else
          state_d = RUN;
`endif
        end
      end
`ifdef FFT_BITREV_EN
      LOAD: begin
        if (!stall) begin
          if (lc_q == L_LAST) begin
            state_d = RUN;
            lc_d    = '0;
          end else begin
            lc_d = lc_q + idx_t'(1);
          end
        end
      end
`endif
      RUN: begin
        if (!stall) begin
          if (k_q == K_LAST) begin
            k_d = '0;
            if (s_q == S_LAST) begin
              state_d = FLUSH;
              f_d     = '0;
            end else if (STAGE_GAP == 0) begin
              s_d = s_q + 4'd1;
            end else begin
              state_d = GAP;
              g_d     = '0;
            end
          end else begin
            k_d = k_q + idx_t'(1);
          end
        end
      end
      GAP: begin
        if (g_q == GAP_LAST) begin
          state_d = RUN;
          s_d     = s_q + 4'd1;
        end else begin
          g_d = g_q + 4'd1;
        end
      end
      FLUSH: begin
        if (f_q == F_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          f_d = f_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      g_q     <= '0;
      f_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      g_q     <= g_d;
      f_q     <= f_d;
      done_q  <= done_d;
    end
  end

`ifdef FFT_BITREV_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lc_q <= '0;
    else        lc_q <= lc_d;
  end

  assign load_valid = (state_q == LOAD) && !stall;

  always_comb begin
    load_addr = '0;
    for (int i = 0; i < LOG2N; i++)
      load_addr[i] = lc_q[LOG2N-1-i];
  end
`endif

  // alignment line: always shifts, stalled cycles enter as bubbles
  logic [ROM_LAT-1:0] pv;
  idx_t               pa [ROM_LAT];
  idx_t               pb [ROM_LAT];
  logic [3:0]         ps [ROM_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        pa[i] <= '0;
        pb[i] <= '0;
        ps[i] <= '0;
      end
    end else begin
      pv[0] <= issue_v;
      pa[0] <= a_i;
      pb[0] <= b_i;
      ps[0] <= s_q;
      for (int i = 1; i < ROM_LAT; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
        pb[i] <= pb[i-1];
        ps[i] <= ps[i-1];
      end
    end
  end

  assign bfly_valid = pv[ROM_LAT-1];
  assign addr_a     = pa[ROM_LAT-1];
  assign addr_b     = pb[ROM_LAT-1];
  assign stage      = ps[ROM_LAT-1];

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Bench for fft_twiddle_sequencer: scoreboard of expected aligned
// butterflies (with cycle stamps) for an 8-point and a 1024-point DUT.
module tb_fft_twiddle_sequencer;

  typedef struct packed {
    int a;
    int b;
    int tw;
    int s;
    int cyc;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic st0 = 1'b0, sl0 = 1'b0, st1 = 1'b0, sl1 = 1'b0;

  logic       bz0, dn0, bv0;
  logic [8:0] tw0;
  logic [2:0] a0, b0;
  logic [3:0] sg0;

  logic       bz1, dn1, bv1;
  logic [8:0] tw1;
  logic [9:0] a1, b1;
  logic [3:0] sg1;

`ifdef FFT_BITREV_EN
  logic       lv0, lv1;
  logic [2:0] la0;
  logic [9:0] la1;
  localparam int LD0 = 8;
  localparam int LD1 = 1024;
`else
  localparam int LD0 = 0;
  localparam int LD1 = 0;
`endif

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  ent_t q0[$];
  ent_t q1[$];
  int done_cnt0 = 0, done_cyc0 = -1;
  int done_cnt1 = 0, done_cyc1 = -1;
  int n1 = 0;
  int twp0 = 0;
  int twh1[3] = '{0, 0, 0};
  ent_t last1 = '0;

  fft_twiddle_sequencer #(.LOG2N(3), .ROM_LAT(1), .STAGE_GAP(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(st0), .stall(sl0),
    .busy(bz0), .done(dn0), .twiddle_addr(tw0), .bfly_valid(bv0),
    .addr_a(a0), .addr_b(b0), .stage(sg0)
`ifdef FFT_BITREV_EN
    , .load_valid(lv0), .load_addr(la0)
`endif
  );

  fft_twiddle_sequencer #(.LOG2N(10), .ROM_LAT(3), .STAGE_GAP(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .stall(sl1),
    .busy(bz1), .done(dn1), .twiddle_addr(tw1), .bfly_valid(bv1),
    .addr_a(a1), .addr_b(b1), .stage(sg1)
`ifdef FFT_BITREV_EN
    , .load_valid(lv1), .load_addr(la1)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  // Expected aligned stream: stage-major, group, then position in group.
  task automatic push(input int sel, input int lg, input int gap,
                      input int lat, input int ld, input int t0,
                      input int ss, input int sk, input int sn);
    int n = 1 << lg;
    int k;
    ent_t e;
    for (int s = 0; s < lg; s++) begin
      int half = 1 << s;
      for (int j = 0; j < n / (2 * half); j++) begin
        for (int p = 0; p < half; p++) begin
          k = j * half + p;
          e.a = j * 2 * half + p;
          e.b = e.a + half;
          e.tw = p * (512 >> s);
          e.s = s;
          e.cyc = t0 + ld + s * (n / 2 + gap) + k + lat +
                  (((s > ss) || (s == ss && k >= sk)) ? sn : 0);
          if (sel == 0) q0.push_back(e);
          else q1.push_back(e);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    ent_t o, e;
    if (dn0) begin
      done_cnt0++;
      done_cyc0 = cyc;
    end
    if (bv0) begin
      o = '{a: int'(a0), b: int'(b0), tw: twp0, s: int'(sg0), cyc: cyc};
      checks++;
      assert (q0.size() > 0) else begin
        errors++;
        $error("FAIL bfly0_extra got a=%0d b=%0d want=none", a0, b0);
      end
      if (q0.size() > 0) begin
        e = q0.pop_front();
        checks++;
        assert (o === e) else begin
          errors++;
          $error("FAIL bfly0 got a=%0d b=%0d tw=%0d s=%0d cyc=%0d want a=%0d b=%0d tw=%0d s=%0d cyc=%0d",
                 o.a, o.b, o.tw, o.s, o.cyc, e.a, e.b, e.tw, e.s, e.cyc);
        end
      end
    end
    twp0 = int'(tw0);
  end

  always @(negedge clk) begin
    ent_t o, e;
    if (dn1) begin
      done_cnt1++;
      done_cyc1 = cyc;
    end
    if (bv1) begin
      o = '{a: int'(a1), b: int'(b1), tw: twh1[2], s: int'(sg1), cyc: cyc};
      n1++;
      last1 = o;
      checks++;
      assert (q1.size() > 0) else begin
        errors++;
        $error("FAIL bfly1_extra got a=%0d b=%0d want=none", a1, b1);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        checks++;
        assert (o === e) else begin
          errors++;
          $error("FAIL bfly1 got a=%0d b=%0d tw=%0d s=%0d cyc=%0d want a=%0d b=%0d tw=%0d s=%0d cyc=%0d",
                 o.a, o.b, o.tw, o.s, o.cyc, e.a, e.b, e.tw, e.s, e.cyc);
        end
      end
    end
    twh1[2] = twh1[1];
    twh1[1] = twh1[0];
    twh1[0] = int'(tw1);
  end

  task automatic run0(input int sn, input bit mid_rst);
    int t0;
    @(negedge clk);
    done_cnt0 = 0;
    done_cyc0 = -1;
    t0 = cyc + 1;
    push(0, 3, 2, 1, LD0, t0, 1, 2, sn);
    st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    chk("busy_first", bz0, 1);
`ifdef FFT_BITREV_EN
    for (int i = 0; i < 8; i++) begin
      logic [2:0] iv, rv;
      iv = 3'(i);
      rv = {iv[0], iv[1], iv[2]};
      chk("load", {lv0, la0}, {1'b1, rv});
      @(negedge clk);
    end
`endif
    if (mid_rst) begin
      while (cyc < t0 + LD0 + 7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("midrst_out", {bz0, dn0, bv0, tw0, a0, b0, sg0}, 0);
      q0.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("midrst_nodone", done_cnt0, 0);
      chk("midrst_idle", bz0, 0);
      return;
    end
    if (sn > 0) begin
      while (cyc < t0 + LD0 + 8) @(negedge clk);
      sl0 = 1'b1;
      for (int i = 0; i < sn; i++) begin
        chk("stall_tw", tw0, 0);
        @(negedge clk);
      end
      sl0 = 1'b0;
    end
    for (int i = 0; i < 300 && done_cyc0 < 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("done_cyc0", done_cyc0, t0 + LD0 + 12 + 4 + 1 + sn);
    chk("done_cnt0", done_cnt0, 1);
    chk("q0_empty", q0.size(), 0);
    chk("busy_end0", bz0, 0);
  endtask

  initial begin
    int t0;
    rst_n = 1'b0;
    st0 = 1'b1;
    st1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst0", {bz0, dn0, bv0, tw0, a0, b0, sg0}, 0);
    chk("rst1", {bz1, dn1, bv1, tw1, a1, b1, sg1}, 0);
    st0 = 1'b0;
    st1 = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_rst", bz0, 0);

    run0(0, 1'b0);
    run0(3, 1'b0);
    run0(0, 1'b1);
    run0(0, 1'b0);

    @(negedge clk);
    t0 = cyc + 1;
    push(1, 10, 2, 3, LD1, t0, 99, 0, 0);
    st1 = 1'b1;
    @(negedge clk);
    st1 = 1'b0;
    for (int i = 0; i < 7000 && done_cyc1 < 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("done_cyc1", done_cyc1, t0 + LD1 + 5120 + 18 + 3);
    chk("done_cnt1", done_cnt1, 1);
    chk("n_bfly1", n1, 5120);
    chk("last_a", last1.a, 511);
    chk("last_b", last1.b, 1023);
    chk("last_tw", last1.tw, 511);
    chk("last_s", last1.s, 9);
    chk("q1_empty", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
